ball_move_ctrl: RTL

- Motion controller sitting directly upstream of the ball bitmap stage. It owns the ball's position and velocity and drives topLeftX/topLeftY into the square-object/bitmap chain.
- Consumes the bitmap's HitEdgeCode together with a collision strobe from the collision detector, and reflects velocity off the struck edges.
- Position updates once per video frame, on startOfFrame, in fixed point.

---
 rtl/ball_pkg.sv | 24 ++
 rtl/hit_edge_accum.sv | 33 +++
 rtl/ball_move_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared constants and types for the ball motion controller.
// Positions are signed fixed point with FIXED_POINT_SHIFT fractional bits.
package ball_pkg;

    localparam int FIXED_POINT_SHIFT = 6;

    // Bit positions inside HitEdgeCode {Left,Top,Right,Bottom}
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int EDGE_W  = 4;
    localparam int POS_W   = 17;
    localparam int SPEED_W = 11;
    localparam int PIX_W   = POS_W - FIXED_POINT_SHIFT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } ball_state_t;

endpackage

// File: rtl/hit_edge_accum.sv
// Per-frame OR accumulator of struck edges. The combined value (stored edges
// plus any edges struck this cycle) is presented for consumption; the store
// is cleared on startOfFrame once that value has been used.
module hit_edge_accum
    import ball_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_of_frame,
    input  logic              collision,
    input  logic [EDGE_W-1:0] hit_edge_code,
    output logic [EDGE_W-1:0] frame_hits
);

    logic [EDGE_W-1:0] acc_q;
    logic [EDGE_W-1:0] acc_d;

    // Fold this cycle's edges in and clear at the frame boundary
    always_comb begin
        frame_hits = acc_q | (collision ? hit_edge_code : '0);
        acc_d      = start_of_frame ? '0 : frame_hits;
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ball_move_ctrl.sv
// Ball motion controller: owns position/velocity, reflects velocity off
// struck edges and advances the position once per video frame.
// Optional feature macro: BALL_GRAVITY_EN (per-frame Y acceleration with
// a +/-MAX_SPEED clamp on the Y speed).
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = -20,
    parameter int MAX_SPEED       = 230,
    parameter int Y_ACCEL         = -1,
    parameter int BOTTOM_LIMIT    = 479,
    parameter int LOST_FRAMES     = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    input  logic               launch,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               ballLost
);

    localparam int CNT_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;

    localparam logic signed [POS_W-1:0]   INIT_X_FP  = POS_W'(INITIAL_X * (1 << FIXED_POINT_SHIFT));
    localparam logic signed [POS_W-1:0]   INIT_Y_FP  = POS_W'(INITIAL_Y * (1 << FIXED_POINT_SHIFT));
    localparam logic signed [PIX_W-1:0]   INIT_X_PIX = PIX_W'(INITIAL_X);
    localparam logic signed [PIX_W-1:0]   INIT_Y_PIX = PIX_W'(INITIAL_Y);
    localparam logic signed [SPEED_W-1:0] LAUNCH_XS  = SPEED_W'(INITIAL_X_SPEED);
    localparam logic signed [SPEED_W-1:0] LAUNCH_YS  = SPEED_W'(INITIAL_Y_SPEED);
    localparam logic signed [PIX_W-1:0]   BOTTOM_PIX = PIX_W'(BOTTOM_LIMIT);
    localparam logic [CNT_W-1:0]          LOST_LAST  = CNT_W'(LOST_FRAMES - 1);
    localparam logic signed [SPEED_W-1:0] SPEED_MIN  = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] SPEED_MAX  = {1'b0, {(SPEED_W-1){1'b1}}};

`ifdef BALL_GRAVITY_EN
    localparam logic signed [SPEED_W:0] ACCEL_W   = (SPEED_W+1)'(Y_ACCEL);
    localparam logic signed [SPEED_W:0] MAX_W     = (SPEED_W+1)'(MAX_SPEED);
    localparam logic signed [SPEED_W:0] NEG_MAX_W = -MAX_W;
    logic signed [SPEED_W:0] ys_wide;
`else
    logic unused_cfg;
    assign unused_cfg = ^{Y_ACCEL, MAX_SPEED};
`endif

    // Negation that maps the most negative speed to the most positive one
    function automatic logic signed [SPEED_W-1:0] neg_sat(input logic signed [SPEED_W-1:0] v);
        if (v == SPEED_MIN) begin
            return SPEED_MAX;
        end
        return -v;
    endfunction

    // Fixed-point position to whole pixels, rounding toward minus infinity
    function automatic logic signed [PIX_W-1:0] to_pixel(input logic signed [POS_W-1:0] p);
        logic signed [POS_W-1:0] s;
        s = p >>> FIXED_POINT_SHIFT;
        return s[PIX_W-1:0];
    endfunction

    // Position plus sign-extended speed, wrapping at the position width
    function automatic logic signed [POS_W-1:0] add_speed(input logic signed [POS_W-1:0]   p,
                                                          input logic signed [SPEED_W-1:0] v);
        return p + {{(POS_W-SPEED_W){v[SPEED_W-1]}}, v};
    endfunction

    ball_state_t               state_q, state_d;
    logic signed [POS_W-1:0]   x_q, x_d, y_q, y_d;
    logic signed [SPEED_W-1:0] xs_q, xs_d, ys_q, ys_d;
    logic [CNT_W-1:0]          lost_cnt_q, lost_cnt_d;
    logic signed [PIX_W-1:0]   top_x_q, top_x_d, top_y_q, top_y_d;
    logic                      ball_lost_q, ball_lost_d;

    logic signed [SPEED_W-1:0] xs_r, ys_r;
    logic signed [POS_W-1:0]   nx, ny;
    logic [EDGE_W-1:0]         frame_hits;

    hit_edge_accum u_hit_edge_accum (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (startOfFrame),
        .collision      (collision),
        .hit_edge_code  (HitEdgeCode),
        .frame_hits     (frame_hits)
    );

    // Next-state, motion and output computation for the serve/run/lost cycle
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xs_d        = xs_q;
        ys_d        = ys_q;
        lost_cnt_d  = lost_cnt_q;
        top_x_d     = top_x_q;
        top_y_d     = top_y_q;
        ball_lost_d = 1'b0;
        xs_r        = xs_q;
        ys_r        = ys_q;
        nx          = x_q;
        ny          = y_q;
`ifdef BALL_GRAVITY_EN
        ys_wide     = '0;
`endif

        case (state_q)
            IDLE: begin
                x_d  = INIT_X_FP;
                y_d  = INIT_Y_FP;
                xs_d = '0;
                ys_d = '0;
                if (startOfFrame && launch) begin
                    xs_d    = LAUNCH_XS;
                    ys_d    = LAUNCH_YS;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (startOfFrame) begin
                    // Reflect only when moving into the struck edge; opposing
                    // edges on one axis cancel.
                    if (frame_hits[EDGE_LEFT] && !frame_hits[EDGE_RIGHT] && (xs_q < 0)) begin
                        xs_r = neg_sat(xs_q);
                    end
                    if (frame_hits[EDGE_RIGHT] && !frame_hits[EDGE_LEFT] && (xs_q > 0)) begin
                        xs_r = neg_sat(xs_q);
                    end
                    if (frame_hits[EDGE_TOP] && !frame_hits[EDGE_BOTTOM] && (ys_q < 0)) begin
                        ys_r = neg_sat(ys_q);
                    end
                    if (frame_hits[EDGE_BOTTOM] && !frame_hits[EDGE_TOP] && (ys_q > 0)) begin
                        ys_r = neg_sat(ys_q);
                    end
`ifdef BALL_GRAVITY_EN
                    ys_wide = {ys_r[SPEED_W-1], ys_r} + ACCEL_W;
                    if (ys_wide > MAX_W) begin
                        ys_r = MAX_W[SPEED_W-1:0];
                    end else if (ys_wide < NEG_MAX_W) begin
                        ys_r = NEG_MAX_W[SPEED_W-1:0];
                    end else begin
                        ys_r = ys_wide[SPEED_W-1:0];
                    end
`endif
                    nx   = add_speed(x_q, xs_r);
                    ny   = add_speed(y_q, ys_r);
                    x_d  = nx;
                    y_d  = ny;
                    xs_d = xs_r;
                    ys_d = ys_r;
                    if (to_pixel(ny) > BOTTOM_PIX) begin
                        state_d     = LOST;
                        ball_lost_d = 1'b1;
                        lost_cnt_d  = '0;
                        xs_d        = '0;
                        ys_d        = '0;
                    end
                end
            end

            LOST: begin
                xs_d = '0;
                ys_d = '0;
                if (startOfFrame) begin
                    if (lost_cnt_q == LOST_LAST) begin
                        state_d = IDLE;
                        x_d     = INIT_X_FP;
                        y_d     = INIT_Y_FP;
                    end else begin
                        lost_cnt_d = lost_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (startOfFrame) begin
            top_x_d = to_pixel(x_d);
            top_y_d = to_pixel(y_d);
        end
    end

    // State, motion and registered output flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= INIT_X_FP;
            y_q         <= INIT_Y_FP;
            xs_q        <= '0;
            ys_q        <= '0;
            lost_cnt_q  <= '0;
            top_x_q     <= INIT_X_PIX;
            top_y_q     <= INIT_Y_PIX;
            ball_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            lost_cnt_q  <= lost_cnt_d;
            top_x_q     <= top_x_d;
            top_y_q     <= top_y_d;
            ball_lost_q <= ball_lost_d;
        end
    end

    assign topLeftX = top_x_q;
    assign topLeftY = top_y_q;
    assign ballLost = ball_lost_q;

endmodule
